ula_arbiter: RTL and testbench

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter_pkg.sv | 19 +
 rtl/ula_arbiter_ula.sv | 30 +++
 rtl/ula_arbiter.sv | 159 +++++++++++++++
 tb/tb_ula_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_arbiter_pkg.sv
// Shared definitions for the ULA arbiter: datapath widths and ULA opcodes.
// Optional feature macro: ULA_ARB_FIXED_PRIO_EN (see ula_arbiter.sv).
package ula_arbiter_pkg;

    // Operand/result width and opcode width.
    localparam int BITS = 8;
    localparam int OP   = 8;

    // ULA opcodes; any value >= 8 is treated as "no operation" and yields 0.
    localparam logic [OP-1:0] OP_NOT = 8'd0;   // ~b
    localparam logic [OP-1:0] OP_AND = 8'd1;
    localparam logic [OP-1:0] OP_OR  = 8'd2;
    localparam logic [OP-1:0] OP_XOR = 8'd3;
    localparam logic [OP-1:0] OP_ADD = 8'd4;
    localparam logic [OP-1:0] OP_SUB = 8'd5;
    localparam logic [OP-1:0] OP_SHL = 8'd6;   // a << b
    localparam logic [OP-1:0] OP_SHR = 8'd7;   // a >> b

endpackage

// File: rtl/ula_arbiter_ula.sv
// Purely combinational ULA used by the arbiter. Arithmetic wraps at the
// operand width; shift amounts of BITS or more produce zero.
module ula_arbiter_ula
    import ula_arbiter_pkg::*;
(
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    input  logic [OP-1:0]   op_in,
    output logic [BITS-1:0] result_out
);

    // Opcode decode; unknown opcodes fall through to zero.
    always_comb begin
        result_out = '0;
        case (op_in)
            OP_NOT:  result_out = ~b_in;
            OP_AND:  result_out = a_in & b_in;
            OP_OR:   result_out = a_in | b_in;
            OP_XOR:  result_out = a_in ^ b_in;
            OP_ADD:  result_out = a_in + b_in;
            OP_SUB:  result_out = a_in - b_in;
            // A logical shift by the full 8-bit amount already yields zero
            // once the amount reaches the operand width.
            OP_SHL:  result_out = a_in << b_in;
            OP_SHR:  result_out = a_in >> b_in;
            default: result_out = '0;
        endcase
    end

endmodule

// File: rtl/ula_arbiter.sv
// Two-requester arbiter in front of a single ULA. A transfer (valid & ready)
// latches the winner's operands; the result appears one cycle later on the
// shared result bus together with a one-cycle resp valid for that requester.
// Optional feature macro: ULA_ARB_FIXED_PRIO_EN -- when defined, requester 0
// always wins and the round-robin pointer is not built.
module ula_arbiter
    import ula_arbiter_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            req0_valid_in,
    input  logic [BITS-1:0] req0_a_in,
    input  logic [BITS-1:0] req0_b_in,
    input  logic [OP-1:0]   req0_op_in,
    output logic            req0_ready_out,
    output logic            resp0_valid_out,
    input  logic            req1_valid_in,
    input  logic [BITS-1:0] req1_a_in,
    input  logic [BITS-1:0] req1_b_in,
    input  logic [OP-1:0]   req1_op_in,
    output logic            req1_ready_out,
    output logic            resp1_valid_out,
    output logic [BITS-1:0] result_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      valid_w;
    logic [1:0]      grant_w;
    logic            xfer_w;
    logic            win_id_w;

    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] b_q, b_d;
    logic [OP-1:0]   op_q, op_d;
    logic            id_q, id_d;
    logic [BITS-1:0] ula_result_w;
    logic [1:0]      resp_valid_w;

    assign valid_w = {req1_valid_in, req0_valid_in};

`ifdef ULA_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant_w = 2'b00;
        if (rst_n_in) begin
            if (valid_w[0]) begin
                grant_w[0] = 1'b1;
            end else if (valid_w[1]) begin
                grant_w[1] = 1'b1;
            end
        end
    end
`else
    // prio_q names the requester that wins a tie; it flips away from the
    // winner on every transfer so the two requesters alternate.
    logic prio_q, prio_d;

    // Round-robin grant: a sole valid requester wins, a tie goes to prio_q.
    always_comb begin
        grant_w = 2'b00;
        if (rst_n_in) begin
            case (valid_w)
                2'b01:   grant_w[0] = 1'b1;
                2'b10:   grant_w[1] = 1'b1;
                2'b11:   grant_w[prio_q] = 1'b1;
                default: grant_w = 2'b00;
            endcase
        end
    end

    // Pointer next state: moves only when a transfer happens.
    always_comb begin
        prio_d = prio_q;
        if (xfer_w) begin
            prio_d = ~win_id_w;
        end
    end

    // Pointer register; after reset requester 0 wins the first tie.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    // Ready is the grant itself, so it is high only while the requester is valid.
    assign req0_ready_out = grant_w[0];
    assign req1_ready_out = grant_w[1];
    assign xfer_w         = |grant_w;
    assign win_id_w       = grant_w[1];

    // Operand capture mux: take the winner's fields on a transfer, else hold.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        id_d = id_q;
        if (xfer_w) begin
            id_d = win_id_w;
            if (win_id_w) begin
                a_d  = req1_a_in;
                b_d  = req1_b_in;
                op_d = req1_op_in;
            end else begin
                a_d  = req0_a_in;
                b_d  = req0_b_in;
                op_d = req0_op_in;
            end
        end
    end

    // Operand and FSM state registers; reset discards any pending response.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
        end
    end

    ula_arbiter_ula u_ula (
        .a_in       (a_q),
        .b_in       (b_q),
        .op_in      (op_q),
        .result_out (ula_result_w)
    );

    // FSM next state and outputs: a transfer always leads to RESP next cycle,
    // and RESP presents the ULA result with a pulse for the latched requester.
    always_comb begin
        state_d      = xfer_w ? ST_RESP : ST_IDLE;
        resp_valid_w = 2'b00;
        result_out   = '0;
        if (state_q == ST_RESP) begin
            result_out         = ula_result_w;
            resp_valid_w[id_q] = 1'b1;
        end
    end

    assign resp0_valid_out = resp_valid_w[0];
    assign resp1_valid_out = resp_valid_w[1];

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: directed scenarios plus randomized
// traffic, checked against a transaction-level model of grants and results.
module tb_ula_arbiter;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       req0_valid_in, req1_valid_in;
    logic [7:0] req0_a_in, req0_b_in, req0_op_in;
    logic [7:0] req1_a_in, req1_b_in, req1_op_in;
    logic       req0_ready_out, req1_ready_out;
    logic       resp0_valid_out, resp1_valid_out;
    logic [7:0] result_out;

    int errors = 0;
    int checks = 0;

    // Model state: last granted requester, and the outstanding response.
    int         last_grant;
    bit         pending;
    int         pend_id;
    logic [7:0] pend_res;

    ula_arbiter dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .req0_valid_in   (req0_valid_in),
        .req0_a_in       (req0_a_in),
        .req0_b_in       (req0_b_in),
        .req0_op_in      (req0_op_in),
        .req0_ready_out  (req0_ready_out),
        .resp0_valid_out (resp0_valid_out),
        .req1_valid_in   (req1_valid_in),
        .req1_a_in       (req1_a_in),
        .req1_b_in       (req1_b_in),
        .req1_op_in      (req1_op_in),
        .req1_ready_out  (req1_ready_out),
        .resp1_valid_out (resp1_valid_out),
        .result_out      (result_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference ULA in plain integer arithmetic.
    function automatic logic [7:0] ref_ula(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = 255 - b;
            1: r = a & b;
            2: r = a | b;
            3: r = a ^ b;
            4: r = (a + b) % 256;
            5: r = (a - b + 256) % 256;
            6: r = (b >= 8) ? 0 : (a * (1 << b)) % 256;
            7: r = (b >= 8) ? 0 : a / (1 << b);
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic model_reset();
        last_grant = 1;   // so requester 0 wins the first tie
        pending    = 1'b0;
        pend_id    = 0;
        pend_res   = 8'h00;
    endtask

    // One clock cycle: drive at negedge, check ready and responses, model
    // the transfer at the posedge, return at the following negedge.
    task automatic step(input string name,
                        input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] op0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] op1);
        int ew;
        req0_valid_in = v0; req0_a_in = a0; req0_b_in = b0; req0_op_in = op0;
        req1_valid_in = v1; req1_a_in = a1; req1_b_in = b1; req1_op_in = op1;
        #1;
        if (v0 && v1) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
            ew = 0;
`else
            ew = (last_grant == 0) ? 1 : 0;
`endif
        end else if (v0) ew = 0;
        else if (v1) ew = 1;
        else ew = -1;

        checks++;
        if (req0_ready_out !== (ew == 0)) begin
            errors++;
            $display("FAIL %s ready0: got %b expected %b", name, req0_ready_out, (ew == 0));
        end
        checks++;
        if (req1_ready_out !== (ew == 1)) begin
            errors++;
            $display("FAIL %s ready1: got %b expected %b", name, req1_ready_out, (ew == 1));
        end
        checks++;
        if (resp0_valid_out !== (pending && pend_id == 0)) begin
            errors++;
            $display("FAIL %s resp0_valid: got %b expected %b", name, resp0_valid_out, (pending && pend_id == 0));
        end
        checks++;
        if (resp1_valid_out !== (pending && pend_id == 1)) begin
            errors++;
            $display("FAIL %s resp1_valid: got %b expected %b", name, resp1_valid_out, (pending && pend_id == 1));
        end
        if (pending) begin
            checks++;
            if (result_out !== pend_res) begin
                errors++;
                $display("FAIL %s result: got %02h expected %02h", name, result_out, pend_res);
            end
        end
        $display("cycle %s v=%b%b grant=%0d resp_pend=%0b id=%0d res=%02h",
                 name, v1, v0, ew, pending, pend_id, result_out);

        @(posedge clk_in);
        if (ew >= 0) begin
            pending    = 1'b1;
            pend_id    = ew;
            pend_res   = (ew == 0) ? ref_ula(a0, b0, op0) : ref_ula(a1, b1, op1);
            last_grant = ew;
        end else begin
            pending = 1'b0;
        end
        @(negedge clk_in);
    endtask

    task automatic idle(input string name);
        step(name, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    // Hold reset with both requesters valid; nothing may be granted or output.
    task automatic test_reset();
        rst_n_in = 1'b0;
        req0_valid_in = 1'b1; req0_a_in = 8'h12; req0_b_in = 8'h34; req0_op_in = 8'd4;
        req1_valid_in = 1'b1; req1_a_in = 8'h56; req1_b_in = 8'h78; req1_op_in = 8'd4;
        model_reset();
        repeat (2) @(negedge clk_in);
        #1;
        checks++;
        if (req0_ready_out !== 1'b0 || req1_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL reset ready: got %b%b expected 00", req1_ready_out, req0_ready_out);
        end
        checks++;
        if (resp0_valid_out !== 1'b0 || resp1_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset resp_valid: got %b%b expected 00", resp1_valid_out, resp0_valid_out);
        end
        checks++;
        if (result_out !== 8'h00) begin
            errors++;
            $display("FAIL reset result: got %02h expected 00", result_out);
        end
        $display("reset held: ready=%b%b resp=%b%b result=%02h",
                 req1_ready_out, req0_ready_out, resp1_valid_out, resp0_valid_out, result_out);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // req0 alone: ADD 255+1 wraps to 0 one cycle after the grant.
    task automatic test_add_wrap();
        step("add_wrap", 1'b1, 8'd255, 8'd1, 8'd4, 1'b0, 8'h00, 8'h00, 8'h00);
        #1;
        checks++;
        if (resp0_valid_out !== 1'b1 || result_out !== 8'h00) begin
            errors++;
            $display("FAIL add_wrap direct: got v=%b r=%02h expected v=1 r=00", resp0_valid_out, result_out);
        end
        step("add_wrap_resp", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    // Both valid continuously from a fresh reset: alternating grants.
    task automatic test_round_robin();
        rst_n_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int i = 0; i < 4; i++)
            step("rr", 1'b1, 8'd0, 8'd1, 8'd5, 1'b1, 8'd255, 8'd2, 8'd6);
        idle("rr_drain");
    endtask

    // Unknown opcode still pulses resp valid with a zero result.
    task automatic test_bad_op();
        step("bad_op", 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hA5, 8'h5A, 8'd9);
        idle("bad_op_resp");
    endtask

    // Reset after a transfer drops the pending response; first tie goes to 0.
    task automatic test_reset_mid();
        step("mid_xfer", 1'b1, 8'd3, 8'd4, 8'd4, 1'b0, 8'h00, 8'h00, 8'h00);
        rst_n_in = 1'b0;
        model_reset();
        #1;
        checks++;
        if (resp0_valid_out !== 1'b0 || resp1_valid_out !== 1'b0 || result_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid outputs: got v=%b%b r=%02h expected v=00 r=00",
                     resp1_valid_out, resp0_valid_out, result_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle("post_rst0");
        idle("post_rst1");
        step("post_rst_tie", 1'b1, 8'd1, 8'd1, 8'd3, 1'b1, 8'd2, 8'd2, 8'd3);
        idle("post_rst_drain");
    endtask

    // Fixed-priority configuration must keep granting requester 0 on ties;
    // in round-robin builds the same stimulus checks alternation again.
    task automatic test_tie_run();
        for (int i = 0; i < 4; i++)
            step("tie_run", 1'b1, 8'd7, 8'd9, 8'd2, 1'b1, 8'd8, 8'd1, 8'd1);
        idle("tie_run_drain");
    endtask

    // SHR then NOT on consecutive cycles.
    task automatic test_back_to_back();
        step("b2b_shr", 1'b1, 8'd255, 8'd2, 8'd7, 1'b0, 8'h00, 8'h00, 8'h00);
        step("b2b_not", 1'b1, 8'h00, 8'h55, 8'd0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle("b2b_drain");
    endtask

    // Randomized traffic, including ignored operand noise on idle requesters.
    task automatic test_random();
        logic       v0, v1;
        logic [7:0] a0, b0, o0, a1, b1, o1;
        for (int i = 0; i < 300; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            a0 = 8'($urandom);
            a1 = 8'($urandom);
            b0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            b1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            o0 = 8'($urandom_range(0, 9));
            o1 = 8'($urandom_range(0, 9));
            step("rand", v0, a0, b0, o0, v1, a1, b1, o1);
        end
        idle("rand_drain");
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_round_robin();
        test_bad_op();
        test_reset_mid();
        test_tie_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
